// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_pkg
// Description : Shared opcode constants, FSM state encoding and instruction
//               field positions for the alu_issue block.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_pkg;

  // Opcodes presented to the downstream ALU
  localparam logic [2:0] c_OP_PASS = 3'b000;
  localparam logic [2:0] c_OP_NOT  = 3'b001;
  localparam logic [2:0] c_OP_ADD  = 3'b010;
  localparam logic [2:0] c_OP_NOR  = 3'b011;
  localparam logic [2:0] c_OP_SUB  = 3'b100;
  localparam logic [2:0] c_OP_NAND = 3'b101;
  localparam logic [2:0] c_OP_AND  = 3'b110;
  localparam logic [2:0] c_OP_SLT  = 3'b111;

  // Instruction word layout: [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2
  localparam int c_INSTR_W = 16;
  localparam int c_FIELD_W = 3;
  localparam int c_OP_LSB  = 13;
  localparam int c_RD_LSB  = 10;
  localparam int c_RS1_LSB = 7;
  localparam int c_RS2_LSB = 4;

  // Issue sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Decoded instruction held for the duration of one issue
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
  } dec_t;

endpackage : alu_issue_pkg
`default_nettype wire

// File: rtl/alu_issue_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_regfile
// Description : General register file, two asynchronous read ports, one
//               synchronous write port, synchronous clear of every entry.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_regfile #(
  parameter int N    = 32,
  parameter int NREG = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we_i,
  input  logic [2:0]   waddr_i,
  input  logic [N-1:0] wdata_i,
  input  logic [2:0]   raddr_a_i,
  output logic [N-1:0] rdata_a_o,
  input  logic [2:0]   raddr_b_i,
  output logic [N-1:0] rdata_b_o
);

  logic [N-1:0] regs_q [NREG];

  // Clear has priority over any write in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Reads see the stored value, never the value being written this cycle
  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule : alu_issue_regfile
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Four-state issue sequencer. Accepts one instruction, reads
//               its operands, presents them to an external combinational
//               ALU, captures the result and writes it back to the register
//               file. External loads share the write port while idle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int N    = 32,
  parameter int NREG = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [c_INSTR_W-1:0] instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic                 load_en,
  input  logic [2:0]           load_addr,
  input  logic [N-1:0]         load_data,
  output logic [2:0]           alu_op,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  input  logic [N-1:0]         alu_result,
  output logic                 done,
  output logic [N-1:0]         result
);

  state_e       state_q, state_d;
  dec_t         dec_q, dec_d;
  logic [2:0]   alu_op_q, alu_op_d;
  logic [N-1:0] opa_q, opa_d;
  logic [N-1:0] opb_q, opb_d;
  logic [N-1:0] result_q, result_d;

  logic         w_rf_we;
  logic [2:0]   w_rf_waddr;
  logic [N-1:0] w_rf_wdata;
  logic [N-1:0] w_rdata_a;
  logic [N-1:0] w_rdata_b;
  logic         w_ready;
  logic         w_done;
  dec_t         w_dec;
  logic         w_unused_instr_bits;

  // Low nibble of the instruction word carries no information
  assign w_unused_instr_bits = ^instr[c_RS2_LSB-1:0];

  assign w_dec.op  = instr[c_OP_LSB  +: c_FIELD_W];
  assign w_dec.rd  = instr[c_RD_LSB  +: c_FIELD_W];
  assign w_dec.rs1 = instr[c_RS1_LSB +: c_FIELD_W];
  assign w_dec.rs2 = instr[c_RS2_LSB +: c_FIELD_W];

  alu_issue_regfile #(
    .N    (N),
    .NREG (NREG)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .we_i      (w_rf_we),
    .waddr_i   (w_rf_waddr),
    .wdata_i   (w_rf_wdata),
    .raddr_a_i (dec_q.rs1),
    .rdata_a_o (w_rdata_a),
    .raddr_b_i (dec_q.rs2),
    .rdata_b_o (w_rdata_b)
  );

  // Next-state, datapath capture enables and register-file write-port mux
  always_comb begin
    state_d    = state_q;
    dec_d      = dec_q;
    alu_op_d   = alu_op_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    result_d   = result_q;
    w_rf_we    = 1'b0;
    w_rf_waddr = load_addr;
    w_rf_wdata = load_data;
    w_ready    = 1'b0;
    w_done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          // A pending load wins the write port and blocks acceptance
          w_rf_we = 1'b1;
        end else begin
          w_ready = 1'b1;
          if (instr_valid) begin
            dec_d   = w_dec;
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        alu_op_d = dec_q.op;
        opa_d    = w_rdata_a;
        opb_d    = w_rdata_b;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        result_d = alu_result;
        state_d  = ST_WB;
      end
      ST_WB: begin
        w_rf_we    = 1'b1;
        w_rf_waddr = dec_q.rd;
        w_rf_wdata = result_q;
        w_done     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      dec_q    <= '0;
      alu_op_q <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      dec_q    <= dec_d;
      alu_op_q <= alu_op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

  // Handshake and pulse are masked while reset is asserted
  assign instr_ready = w_ready & ~rst;
  assign done        = w_done & ~rst;
  assign alu_op      = alu_op_q;
  assign alu_a       = opa_q;
  assign alu_b       = opb_q;
  assign result      = result_q;

endmodule : alu_issue
`default_nettype wire

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: N, default 32, datapath and register width in bits.
REQ-002 Parameter: NREG, default 8, number of general registers; fixed at 8 by the 3-bit register fields.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: instr  input  16  instruction word: [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2, [3:0] ignored.
REQ-006 Port: instr_valid  input  1  instr is presented.
REQ-007 Port: instr_ready  output  1  block accepts instr this cycle.
REQ-008 Port: load_en  input  1  external register write request.
REQ-009 Port: load_addr  input  3  external write register index.
REQ-010 Port: load_data  input  N  external write data.
REQ-011 Port: alu_op  output  3  opcode driven to the downstream ALU.
REQ-012 Port: alu_a  output  N  first ALU operand (rs1 value).
REQ-013 Port: alu_b  output  N  second ALU operand (rs2 value).
REQ-014 Port: alu_result  input  N  combinational result returned by the ALU.
REQ-015 Port: done  output  1  one-cycle pulse when a result is written back.
REQ-016 Port: result  output  N  last written-back value, held until the next write-back.

Function
REQ-017 FSM states SHALL be IDLE, READ, EXEC, WB; reset state IDLE.
REQ-018 instr_ready SHALL be 1 only in IDLE with load_en=0; it is 0 in all other states.
REQ-019 IDLE: instr_valid & instr_ready SHALL latch op/rd/rs1/rs2 and go to READ.
REQ-020 IDLE: load_en=1 SHALL write load_data to reg[load_addr] that edge; load has priority over instruction acceptance.
REQ-021 load_en outside IDLE SHALL be ignored (no register change).
REQ-022 READ: operand registers SHALL capture reg[rs1], reg[rs2]; next state EXEC.
REQ-023 EXEC: alu_op, alu_a, alu_b SHALL be stable; alu_result SHALL be captured into result at the end of EXEC; next state WB.
REQ-024 WB: reg[rd] SHALL be written with the captured result and done pulses 1 for exactly this cycle; next state IDLE.
REQ-025 Latency: instruction accepted at edge T, done high in the cycle after edge T+2, regfile updated at edge T+3; throughput one instruction per 4 cycles.
REQ-026 rs1, rs2 and rd MAY be equal; reads SHALL observe the value before the current instruction's write-back.
REQ-027 alu_op/alu_a/alu_b SHALL hold their last values outside EXEC (no glitch-to-zero requirement).
REQ-028 All 8 registers SHALL be writable; no hard-wired zero register.
REQ-029 No arithmetic in this block; width of result equals N, taken unchanged from alu_result.

Reset
REQ-030 rst=1 at any edge, including mid-instruction, SHALL force IDLE, abandon the instruction without write-back, and clear all registers to 0.
REQ-031 During and after reset: done=0, result=0, alu_op=0, alu_a=0, alu_b=0; instr_ready=0 while rst=1.

Structure
REQ-032 Shared package SHALL hold the opcode constants (000 PASS, 001 NOT, 010 ADD, 011 NOR, 100 SUB, 101 NAND, 110 AND, 111 SLT), the FSM state encoding and the instruction field positions.
REQ-033 The register file SHALL be a sub-module regfile (two async read ports, one sync write port, sync clear); write-port mux between load and WB lives in alu_issue.

Verification
REQ-034 Load r1=5, r2=3; issue ADD r3,r1,r2 -> alu_a=5, alu_b=3, alu_op=010 in EXEC; done after 3 cycles; r3=8, result=8.
REQ-035 Load r1=3, r2=5; issue SUB r4,r1,r2 then SLT r5,r1,r2 -> r4=0xFFFFFFFE, r5=1; instr_ready low during each 3 busy cycles.
REQ-036 Issue ADD r1,r1,r1 with r1=7 -> operands both 7, r1=14 after WB.
REQ-037 Assert load_en and instr_valid together in IDLE -> load written, instr not accepted (instr_ready=0); instr accepted next cycle.
REQ-038 Assert rst during EXEC of ADD r3 -> no done pulse, r3=0, all outputs 0, FSM IDLE next cycle.
REQ-039 load_en asserted in READ with load_addr=2, load_data=9 -> r2 unchanged.
